fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 97 +++++++++
 tb/tb_fetch_unit.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding the 9-bit decoder.
// Holds the program counter, addresses instruction memory, presents the
// fetched word with a valid flag, redirects the PC via a branch-target LUT
// and runs a start/done handshake with the top level.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   start                 pulse: begin/restart execution at PC 0 (ignored in RUN)
//   stall                 hold PC and counter while running
//   last_pc               address of the final program instruction
//   imem_addr, imem_data  instruction memory address / combinational read data
//   instr, instr_valid    word to decoder and its valid flag
//   branch_en, branch_idx decoder branch request (LUT index in bits [4:0])
//   lut_we/waddr/wdata    branch-target LUT write port
//   pc, done, cycle_count program counter, finished flag, non-stalled RUN cycles
module fetch_unit #(
  parameter int PC_WIDTH    = 10,
  parameter int INSTR_WIDTH = 9,
  parameter int LUT_DEPTH   = 32,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stall,
  input  logic [PC_WIDTH-1:0]    last_pc,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   instr_valid,
  input  logic                   branch_en,
  input  logic [7:0]             branch_idx,
  input  logic                   lut_we,
  input  logic [4:0]             lut_waddr,
  input  logic [PC_WIDTH-1:0]    lut_wdata,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   done,
  output logic [CNT_WIDTH-1:0]   cycle_count
);

  // state | meaning
  // IDLE  | after reset, waiting for start
  // RUN   | fetching and advancing the PC
  // DONE  | last_pc executed, done held until next start
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]          state;
  logic [PC_WIDTH-1:0] lut [LUT_DEPTH];
  logic                unused_idx_bits;

  // Upper index bits carry no meaning for a 32-entry table.
  assign unused_idx_bits = ^branch_idx[7:5];

  assign imem_addr   = pc;
  assign instr_valid = (state == S_RUN) && !stall;
  // Zero outside RUN: an all-zero word is a register op the decoder must
  // gate with instr_valid.
  assign instr       = (state == S_RUN) ? imem_data : '0;
  assign done        = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= '0;
      cycle_count <= '0;
      for (int i = 0; i < LUT_DEPTH; i++) lut[i] <= '0;
    end else begin
      // Branch reads below see the pre-write LUT contents (old value wins).
      if (lut_we) lut[lut_waddr] <= lut_wdata;

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_RUN;
            pc          <= '0;
            cycle_count <= '0;
          end
        end
        S_RUN: begin
          if (!stall) begin
            if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
            if (branch_en)
              pc <= lut[branch_idx[4:0]];
            else if (pc == last_pc)
              state <= S_DONE;
            else
              pc <= pc + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stall, branch_en, lut_we;
  logic [9:0] last_pc, lut_wdata;
  logic [7:0] branch_idx;
  logic [4:0] lut_waddr;
  wire  [9:0] imem_addr, pc;
  wire  [8:0] imem_data, instr;
  wire        instr_valid, done;
  wire [15:0] cycle_count;

  logic [8:0] imem [1024];
  assign imem_data = imem[imem_addr];

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .last_pc(last_pc),
    .imem_addr(imem_addr), .imem_data(imem_data), .instr(instr),
    .instr_valid(instr_valid), .branch_en(branch_en), .branch_idx(branch_idx),
    .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .pc(pc), .done(done), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: running/finished flags, integer PC, counter and table.
  bit m_run, m_done;
  int m_pc, m_cnt;
  int m_lut [32];

  task automatic model_reset();
    m_run = 0; m_done = 0; m_pc = 0; m_cnt = 0;
    for (int i = 0; i < 32; i++) m_lut[i] = 0;
  endtask

  task automatic clear_inputs();
    start = 0; stall = 0; branch_en = 0; branch_idx = 0;
    lut_we = 0; lut_waddr = 0; lut_wdata = 0;
  endtask

  // Called right after a negedge with inputs set; optionally compares,
  // advances one clock, updates the model, returns at the next negedge.
  task automatic cyc(input bit chk);
    int  tgt;
    bit  exp_v;
    logic [8:0] exp_i;
    #1;
    if (chk) begin
      exp_v = m_run && !stall;
      exp_i = m_run ? imem[m_pc] : 9'd0;
      n_checks++;
      if (pc !== 10'(m_pc)) $display("FAIL pc: got %h required %h", pc, 10'(m_pc));
      else n_pass++;
      n_checks++;
      if (imem_addr !== 10'(m_pc)) $display("FAIL imem_addr: got %h required %h", imem_addr, 10'(m_pc));
      else n_pass++;
      n_checks++;
      if (instr_valid !== exp_v) $display("FAIL instr_valid: got %b required %b", instr_valid, exp_v);
      else n_pass++;
      n_checks++;
      if (instr !== exp_i) $display("FAIL instr: got %h required %h", instr, exp_i);
      else n_pass++;
      n_checks++;
      if (done !== m_done) $display("FAIL done: got %b required %b", done, m_done);
      else n_pass++;
      n_checks++;
      if (cycle_count !== 16'(m_cnt)) $display("FAIL cycle_count: got %0d required %0d", cycle_count, m_cnt);
      else n_pass++;
    end
    @(posedge clk);
    tgt = m_lut[branch_idx[4:0]];
    if (m_run) begin
      if (!stall) begin
        if (m_cnt < 65535) m_cnt++;
        if (branch_en) m_pc = tgt;
        else if (m_pc == int'(last_pc)) begin m_run = 0; m_done = 1; end
        else m_pc = (m_pc + 1) % 1024;
      end
    end else if (start) begin
      m_run = 1; m_done = 0; m_pc = 0; m_cnt = 0;
    end
    if (lut_we) m_lut[lut_waddr] = int'(lut_wdata);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_inputs();
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic pulse_start();
    start = 1; cyc(1); start = 0;
  endtask

  task automatic lut_load(input int idx, input int val);
    lut_we = 1; lut_waddr = 5'(idx); lut_wdata = 10'(val);
    cyc(1);
    lut_we = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 1024; i++) imem[i] = 9'h1A5;
    last_pc = 10'h3FF;
    do_reset();
    cyc(1);
    cyc(1);
  endtask

  task automatic test_linear();
    do_reset();
    for (int i = 0; i < 4; i++) imem[i] = 9'(9'h101 + i);
    last_pc = 10'd3;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (pc !== 10'(i) || instr_valid !== 1'b1)
        $display("FAIL linear_seq: got pc %h valid %b required pc %h valid 1", pc, instr_valid, 10'(i));
      else n_pass++;
      cyc(1);
    end
    #1;
    n_checks++;
    if (done !== 1'b1 || cycle_count !== 16'd4 || instr !== 9'd0)
      $display("FAIL linear_end: got done %b cnt %0d instr %h required 1 4 000", done, cycle_count, instr);
    else n_pass++;
    cyc(1);
  endtask

  task automatic test_branch();
    int seq [5] = '{0, 1, 2, 32, 33};
    do_reset();
    last_pc = 10'h021;
    lut_load(5, 10'h020);
    pulse_start();
    branch_idx = 8'd5;
    for (int k = 0; k < 5; k++) begin
      branch_en = (m_pc == 2);
      #1;
      n_checks++;
      if (pc !== 10'(seq[k])) $display("FAIL branch_seq[%0d]: got %h required %h", k, pc, 10'(seq[k]));
      else n_pass++;
      cyc(1);
    end
    branch_en = 0;
    #1;
    n_checks++;
    if (done !== 1'b1 || cycle_count !== 16'd5)
      $display("FAIL branch_end: got done %b cnt %0d required 1 5", done, cycle_count);
    else n_pass++;
    cyc(1);
  endtask

  task automatic test_stall();
    do_reset();
    last_pc = 10'h0FF;
    lut_load(9, 10'h0AA);
    pulse_start();
    cyc(1);
    stall = 1; branch_en = 1; branch_idx = 8'd9;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (pc !== 10'd1 || instr_valid !== 1'b0 || cycle_count !== 16'd1)
        $display("FAIL stall_hold: got pc %h valid %b cnt %0d required 001 0 1", pc, instr_valid, cycle_count);
      else n_pass++;
      cyc(1);
    end
    stall = 0; branch_en = 0;
    cyc(1);
    #1;
    n_checks++;
    if (pc !== 10'd2) $display("FAIL stall_resume: got %h required 002", pc);
    else n_pass++;
    cyc(1);
  endtask

  task automatic test_lut_same_cycle();
    do_reset();
    last_pc = 10'h3FF;
    lut_load(7, 10'h050);
    pulse_start();
    branch_en = 1; branch_idx = 8'hE7;
    lut_we = 1; lut_waddr = 5'd7; lut_wdata = 10'h100;
    cyc(1);
    lut_we = 0; branch_en = 0;
    #1;
    n_checks++;
    if (pc !== 10'h050) $display("FAIL lut_old_value: got %h required 050", pc);
    else n_pass++;
    branch_en = 1; branch_idx = 8'd7;
    cyc(1);
    branch_en = 0;
    #1;
    n_checks++;
    if (pc !== 10'h100) $display("FAIL lut_new_value: got %h required 100", pc);
    else n_pass++;
    cyc(1);
  endtask

  task automatic test_branch_at_last();
    do_reset();
    last_pc = 10'd2;
    pulse_start();
    cyc(1); cyc(1);
    branch_en = 1; branch_idx = 8'd3;
    cyc(1);
    branch_en = 0;
    #1;
    n_checks++;
    if (pc !== 10'd0 || done !== 1'b0 || instr_valid !== 1'b1)
      $display("FAIL branch_at_last: got pc %h done %b valid %b required 000 0 1", pc, done, instr_valid);
    else n_pass++;
    cyc(1);
    start = 1;
    cyc(1);
    start = 0;
    #1;
    n_checks++;
    if (pc !== 10'd2 || cycle_count !== 16'd5)
      $display("FAIL start_in_run: got pc %h cnt %0d required 002 5", pc, cycle_count);
    else n_pass++;
    cyc(1);
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    last_pc = 10'h03F;
    lut_load(5, 10'h123);
    pulse_start();
    for (int k = 0; k < 16; k++) cyc(1);
    rst_n = 0;
    #1;
    n_checks++;
    if (pc !== 10'd0 || done !== 1'b0 || instr_valid !== 1'b0 || cycle_count !== 16'd0)
      $display("FAIL async_reset: got pc %h done %b valid %b cnt %0d required 000 0 0 0",
               pc, done, instr_valid, cycle_count);
    else n_pass++;
    model_reset();
    #1;
    rst_n = 1;
    @(negedge clk);
    pulse_start();
    branch_en = 1; branch_idx = 8'd5;
    cyc(1);
    branch_en = 0;
    #1;
    n_checks++;
    if (pc !== 10'd0) $display("FAIL lut_cleared: got %h required 000", pc);
    else n_pass++;
    cyc(1);
  endtask

  task automatic test_saturation();
    do_reset();
    last_pc = 10'd2;
    pulse_start();
    for (int k = 0; k < 65540; k++) begin
      last_pc = 10'((m_pc + 2) % 1024);
      cyc(k > 65530);
    end
    #1;
    n_checks++;
    if (cycle_count !== 16'hFFFF) $display("FAIL saturation: got %h required ffff", cycle_count);
    else n_pass++;
    cyc(1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 1024; i++) imem[i] = 9'($urandom);
    do_reset();
    last_pc = 10'($urandom_range(0, 63));
    for (int k = 0; k < 3000; k++) begin
      start      = ($urandom_range(0, 40) == 0);
      stall      = ($urandom_range(0, 3) == 0);
      branch_en  = ($urandom_range(0, 5) == 0);
      branch_idx = 8'($urandom);
      lut_we     = ($urandom_range(0, 2) == 0);
      lut_waddr  = 5'($urandom);
      lut_wdata  = 10'($urandom_range(0, 63));
      if ($urandom_range(0, 15) == 0) last_pc = 10'($urandom_range(0, 63));
      cyc(1);
    end
    clear_inputs();
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    last_pc = 0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_linear();
    test_branch();
    test_stall();
    test_lut_same_cycle();
    test_branch_at_last();
    test_reset_mid_run();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
